// File: rtl/mcu_dmi_pkg.sv
// mcu_dmi_pkg
//   Shared definitions for the JTAG-side DMI request controller:
//   controller FSM states, DMI op codes and TAP status codes.
package mcu_dmi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2
  } dmi_state_e;

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_RD  = 2'd1;
  localparam logic [1:0] OP_WR  = 2'd2;

  localparam logic [1:0] STAT_OK     = 2'd0;
  localparam logic [1:0] STAT_FAILED = 2'd2;
  localparam logic [1:0] STAT_BUSY   = 2'd3;

  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/mcu_dmi_jtag_ctrl.sv
// mcu_dmi_jtag_ctrl
//   Turns TAP read/write pulses into single DMI requests, waits for the
//   response with a timeout, and keeps the sticky DMI error status the
//   debugger polls through the TAP.
//
// Ports
//   tck, trst                    TAP clock, async active-low reset
//   wr_en, rd_en                 one-cycle TAP op pulses
//   wr_addr, wr_data             DMI address / write data from the TAP
//   dmi_reset, dmi_hard_reset    TAP dmireset / dmihardreset pulses
//   rd_data, rd_status           last read data and op status for the TAP
//   dmi_stat, idle               sticky status, run-test-idle hint
//   dmi_req_*                    request channel (valid/ready)
//   dmi_rsp_*                    response channel (always accepted)
module mcu_dmi_jtag_ctrl
  import mcu_dmi_pkg::*;
#(
  parameter int unsigned AWIDTH    = 7,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [2:0]  IDLE_HINT = 3'd1
) (
  input  logic              tck,
  input  logic              trst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              dmi_reset,
  input  logic              dmi_hard_reset,
  output logic [31:0]       rd_data,
  output logic [1:0]        rd_status,
  output logic [1:0]        dmi_stat,
  output logic [2:0]        idle,
  output logic              dmi_req_valid,
  input  logic              dmi_req_ready,
  output logic [AWIDTH-1:0] dmi_req_addr,
  output logic [31:0]       dmi_req_data,
  output logic [1:0]        dmi_req_op,
  input  logic              dmi_rsp_valid,
  input  logic [31:0]       dmi_rsp_data,
  input  logic              dmi_rsp_error
);

  // The counter holds TIMEOUT-1 during the last permitted WAIT_RSP cycle.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  dmi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        sticky_q, sticky_d;
  logic              discard_q, discard_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        op_q, op_d;
  logic              tap_op;
  logic              tap_any;

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sticky_q  <= STAT_OK;
      discard_q <= 1'b0;
      rd_data_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      op_q      <= OP_NOP;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
      discard_q <= discard_d;
      rd_data_q <= rd_data_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      op_q      <= op_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sticky_d  = sticky_q;
    discard_d = discard_q;
    rd_data_d = rd_data_q;
    addr_d    = addr_q;
    data_d    = data_q;
    op_d      = op_q;
    tap_op    = wr_en ^ rd_en;
    tap_any   = wr_en | rd_en;

    if (dmi_hard_reset) begin
      // An aborted request may still be answered later; remember to drop it.
      state_d  = ST_IDLE;
      sticky_d = STAT_OK;
      cnt_d    = '0;
      if (state_q != ST_IDLE) discard_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // dmi_reset outranks a new op arriving in the same cycle.
          if (tap_op && !dmi_reset && (sticky_q == STAT_OK)) begin
            addr_d    = wr_addr;
            data_d    = wr_data;
            op_d      = wr_en ? OP_WR : OP_RD;
            discard_d = 1'b0;
            state_d   = ST_REQ;
          end else if (dmi_rsp_valid && discard_q) begin
            discard_d = 1'b0;
          end
        end
        ST_REQ: begin
          if (tap_any && (sticky_q == STAT_OK)) sticky_d = STAT_BUSY;
          if (dmi_req_ready) begin
            state_d = ST_WAIT_RSP;
            cnt_d   = '0;
          end
        end
        ST_WAIT_RSP: begin
          if (tap_any && (sticky_q == STAT_OK)) sticky_d = STAT_BUSY;
          cnt_d = cnt_q + 1'b1;
          // A response in the final cycle takes precedence over the timeout.
          if (dmi_rsp_valid) begin
            state_d = ST_IDLE;
            if (op_q == OP_RD) rd_data_d = dmi_rsp_data;
            if (dmi_rsp_error) sticky_d = STAT_FAILED;
          end else if (cnt_q == TMO_LAST) begin
            state_d   = ST_IDLE;
            sticky_d  = STAT_FAILED;
            discard_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (dmi_reset) sticky_d = STAT_OK;
    end
  end

  always_comb begin
    rd_status = STAT_OK;
    if (sticky_q != STAT_OK)     rd_status = sticky_q;
    else if (state_q != ST_IDLE) rd_status = STAT_BUSY;
  end

  assign rd_data       = rd_data_q;
  assign dmi_stat      = sticky_q;
  assign idle          = IDLE_HINT;
  assign dmi_req_valid = (state_q == ST_REQ);
  assign dmi_req_addr  = addr_q;
  assign dmi_req_data  = data_q;
  assign dmi_req_op    = op_q;

endmodule

// File: tb/tb_mcu_dmi_jtag_ctrl.sv
// tb_mcu_dmi_jtag_ctrl
//   Directed bench for mcu_dmi_jtag_ctrl. A transaction-level model tracks
//   what the TAP should observe; every cycle the outputs are compared with
//   it, and literal expectations at key points pin the model itself.
module tb_mcu_dmi_jtag_ctrl;
  import mcu_dmi_pkg::*;

  localparam int         AW       = 7;
  localparam int         TMO      = 4;
  localparam logic [2:0] IDLE_VAL = 3'd5;

  logic          tck = 1'b0;
  logic          trst = 1'b0;
  logic          wr_en = 1'b0, rd_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic          dmi_reset = 1'b0, dmi_hard_reset = 1'b0;
  logic [31:0]   rd_data;
  logic [1:0]    rd_status, dmi_stat;
  logic [2:0]    idle;
  logic          dmi_req_valid;
  logic          dmi_req_ready = 1'b0;
  logic [AW-1:0] dmi_req_addr;
  logic [31:0]   dmi_req_data;
  logic [1:0]    dmi_req_op;
  logic          dmi_rsp_valid = 1'b0;
  logic [31:0]   dmi_rsp_data = '0;
  logic          dmi_rsp_error = 1'b0;

  mcu_dmi_jtag_ctrl #(.AWIDTH(AW), .TIMEOUT(TMO), .IDLE_HINT(IDLE_VAL)) dut (
    .tck(tck), .trst(trst), .wr_en(wr_en), .rd_en(rd_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .dmi_reset(dmi_reset), .dmi_hard_reset(dmi_hard_reset),
    .rd_data(rd_data), .rd_status(rd_status), .dmi_stat(dmi_stat), .idle(idle),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
    .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
    .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_data(dmi_rsp_data), .dmi_rsp_error(dmi_rsp_error)
  );

  always #5 tck = ~tck;

  int vec_count = 0;
  int err_count = 0;
  int n_reqs    = 0;
  bit check_en  = 1'b0;

  // Transaction-level model: where the single outstanding op is.
  typedef enum {M_FREE, M_ASKING, M_WAITING} m_phase_e;
  m_phase_e      m_phase;
  int            m_waited;
  logic [1:0]    m_sticky;
  bit            m_discard;
  logic [31:0]   m_rd_data;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_data;
  logic [1:0]    m_op;

  always @(posedge tck or negedge trst) begin
    if (!trst) begin
      m_phase = M_FREE; m_waited = 0; m_sticky = 2'd0; m_discard = 1'b0;
      m_rd_data = '0; m_addr = '0; m_data = '0; m_op = 2'd0;
    end else if (dmi_hard_reset) begin
      if (m_phase != M_FREE) m_discard = 1'b1;
      m_phase  = M_FREE;
      m_sticky = 2'd0;
    end else begin
      case (m_phase)
        M_FREE: begin
          if (!dmi_reset && (wr_en != rd_en) && m_sticky == 2'd0) begin
            m_addr = wr_addr; m_data = wr_data;
            m_op = wr_en ? 2'd2 : 2'd1;
            m_discard = 1'b0;
            m_phase = M_ASKING;
          end else if (dmi_rsp_valid && m_discard) begin
            m_discard = 1'b0;
          end
        end
        M_ASKING: begin
          if ((wr_en || rd_en) && m_sticky == 2'd0) m_sticky = 2'd3;
          if (dmi_req_ready) begin m_phase = M_WAITING; m_waited = 0; end
        end
        M_WAITING: begin
          if ((wr_en || rd_en) && m_sticky == 2'd0) m_sticky = 2'd3;
          m_waited++;
          if (dmi_rsp_valid) begin
            if (m_op == 2'd1) m_rd_data = dmi_rsp_data;
            if (dmi_rsp_error) m_sticky = 2'd2;
            m_phase = M_FREE;
          end else if (m_waited == TMO) begin
            m_sticky = 2'd2; m_discard = 1'b1; m_phase = M_FREE;
          end
        end
        default: m_phase = M_FREE;
      endcase
      if (dmi_reset) m_sticky = 2'd0;
    end
  end

  always @(posedge tck)
    if (trst && dmi_req_valid && dmi_req_ready) n_reqs++;

  task automatic checkOutput(input string tag);
    logic [1:0] exp_status;
    logic       exp_valid;
    exp_valid  = (m_phase == M_ASKING);
    exp_status = (m_sticky != 2'd0) ? m_sticky : ((m_phase != M_FREE) ? 2'd3 : 2'd0);
    vec_count++;
    if (rd_data !== m_rd_data || rd_status !== exp_status || dmi_stat !== m_sticky ||
        idle !== IDLE_VAL || dmi_req_valid !== exp_valid || dmi_req_addr !== m_addr ||
        dmi_req_data !== m_data || dmi_req_op !== m_op) begin
      err_count++;
      $display("[TB] FAIL %s t=%0t got rd=%h st=%0d stat=%0d idle=%0d v=%b a=%h d=%h op=%0d want rd=%h st=%0d stat=%0d idle=%0d v=%b a=%h d=%h op=%0d",
               tag, $time, rd_data, rd_status, dmi_stat, idle, dmi_req_valid, dmi_req_addr,
               dmi_req_data, dmi_req_op, m_rd_data, exp_status, m_sticky, IDLE_VAL, exp_valid,
               m_addr, m_data, m_op);
    end
  endtask

  task automatic checkLiteral(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      err_count++;
      $display("[TB] FAIL %s t=%0t got %h want %h", tag, $time, act, exp);
    end
  endtask

  always @(negedge tck) if (check_en) checkOutput("cycle");

  task automatic tick(input int n);
    repeat (n) begin @(posedge tck); #1; end
  endtask

  task automatic applyStimulus(input logic we, input logic re, input logic [AW-1:0] a,
                               input logic [31:0] d, input logic dr, input logic dhr);
    wr_en = we; rd_en = re; wr_addr = a; wr_data = d;
    dmi_reset = dr; dmi_hard_reset = dhr;
    tick(1);
    wr_en = 1'b0; rd_en = 1'b0; dmi_reset = 1'b0; dmi_hard_reset = 1'b0;
  endtask

  task automatic sendRsp(input logic [31:0] d, input logic e);
    dmi_rsp_valid = 1'b1; dmi_rsp_data = d; dmi_rsp_error = e;
    tick(1);
    dmi_rsp_valid = 1'b0; dmi_rsp_error = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    check_en = 1'b1;
    tick(1);
    checkLiteral("reset_rd_data", rd_data, 32'h0);
    checkLiteral("reset_idle", {29'd0, idle}, 32'd5);
    checkLiteral("reset_valid", {31'd0, dmi_req_valid}, 32'd0);
    tick(1);
    trst = 1'b1;
    tick(1);

    // Plain read, response in the third wait cycle.
    $display("[TB] read with response");
    dmi_req_ready = 1'b1;
    applyStimulus(1'b0, 1'b1, 7'h11, 32'h0, 1'b0, 1'b0);
    checkLiteral("read_valid_next", {31'd0, dmi_req_valid}, 32'd1);
    checkLiteral("read_addr", {25'd0, dmi_req_addr}, 32'h11);
    checkLiteral("read_op", {30'd0, dmi_req_op}, 32'd1);
    tick(3);
    sendRsp(32'hDEADBEEF, 1'b0);
    checkLiteral("read_data", rd_data, 32'hDEADBEEF);
    checkLiteral("read_status", {30'd0, rd_status}, 32'd0);
    checkLiteral("read_one_req", n_reqs, 32'd1);

    // Op while busy goes sticky; dmireset clears it without aborting.
    $display("[TB] busy op then dmireset");
    applyStimulus(1'b0, 1'b1, 7'h22, 32'h0, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b0, 7'h33, 32'hAAAA5555, 1'b0, 1'b0);
    checkLiteral("busy_status", {30'd0, rd_status}, 32'd3);
    checkLiteral("busy_stat", {30'd0, dmi_stat}, 32'd3);
    applyStimulus(1'b0, 1'b0, 7'h0, 32'h0, 1'b1, 1'b0);
    checkLiteral("dmireset_stat", {30'd0, dmi_stat}, 32'd0);
    checkLiteral("dmireset_inflight", {30'd0, rd_status}, 32'd3);
    sendRsp(32'h12345678, 1'b0);
    checkLiteral("first_op_done", rd_data, 32'h12345678);
    checkLiteral("two_reqs", n_reqs, 32'd2);

    // Timeout after exactly TMO wait cycles; late response is dropped.
    $display("[TB] timeout");
    applyStimulus(1'b0, 1'b1, 7'h05, 32'h0, 1'b0, 1'b0);
    tick(4);
    checkLiteral("tmo_last_cycle_busy", {30'd0, rd_status}, 32'd3);
    tick(1);
    checkLiteral("tmo_stat", {30'd0, dmi_stat}, 32'd2);
    checkLiteral("tmo_valid", {31'd0, dmi_req_valid}, 32'd0);
    sendRsp(32'hBAD0BAD0, 1'b0);
    checkLiteral("late_rsp_dropped", rd_data, 32'h12345678);
    applyStimulus(1'b0, 1'b0, 7'h0, 32'h0, 1'b1, 1'b0);

    // Response in the timeout cycle wins.
    $display("[TB] response on timeout cycle");
    applyStimulus(1'b0, 1'b1, 7'h06, 32'h0, 1'b0, 1'b0);
    tick(4);
    sendRsp(32'hCAFEF00D, 1'b0);
    checkLiteral("edge_rsp_data", rd_data, 32'hCAFEF00D);
    checkLiteral("edge_rsp_stat", {30'd0, dmi_stat}, 32'd0);

    // Hard reset while stalled in REQ.
    $display("[TB] hard reset in REQ");
    dmi_req_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 7'h44, 32'h0BADCAFE, 1'b0, 1'b0);
    tick(1);
    checkLiteral("stall_data", dmi_req_data, 32'h0BADCAFE);
    applyStimulus(1'b0, 1'b1, 7'h45, 32'h0, 1'b0, 1'b0);
    checkLiteral("stall_busy", {30'd0, dmi_stat}, 32'd3);
    applyStimulus(1'b0, 1'b0, 7'h0, 32'h0, 1'b0, 1'b1);
    checkLiteral("hard_valid", {31'd0, dmi_req_valid}, 32'd0);
    checkLiteral("hard_status", {30'd0, rd_status}, 32'd0);
    sendRsp(32'h11112222, 1'b1);
    checkLiteral("discard_data", rd_data, 32'hCAFEF00D);
    checkLiteral("discard_stat", {30'd0, dmi_stat}, 32'd0);
    dmi_req_ready = 1'b1;

    // Write error blocks further ops until dmireset.
    $display("[TB] write error");
    applyStimulus(1'b1, 1'b0, 7'h10, 32'h00005A5A, 1'b0, 1'b0);
    tick(1);
    sendRsp(32'hFFFFFFFF, 1'b1);
    checkLiteral("werr_stat", {30'd0, dmi_stat}, 32'd2);
    checkLiteral("werr_rd_data", rd_data, 32'hCAFEF00D);
    applyStimulus(1'b0, 1'b1, 7'h12, 32'h0, 1'b0, 1'b0);
    checkLiteral("blocked_valid", {31'd0, dmi_req_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 7'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 7'h12, 32'h0, 1'b0, 1'b0);
    checkLiteral("unblocked_valid", {31'd0, dmi_req_valid}, 32'd1);
    tick(1);
    sendRsp(32'h0000ABCD, 1'b0);
    checkLiteral("unblocked_data", rd_data, 32'h0000ABCD);

    // Both pulses together and a stray response are both ignored.
    applyStimulus(1'b1, 1'b1, 7'h13, 32'h0, 1'b0, 1'b0);
    checkLiteral("both_ignored", {31'd0, dmi_req_valid}, 32'd0);
    sendRsp(32'h77777777, 1'b1);
    checkLiteral("stray_rsp", rd_data, 32'h0000ABCD);

    // Async reset in WAIT_RSP.
    $display("[TB] trst in WAIT_RSP");
    applyStimulus(1'b0, 1'b1, 7'h7F, 32'h0, 1'b0, 1'b0);
    tick(1);
    @(posedge tck);
    #2 trst = 1'b0;
    #1;
    checkOutput("async_reset");
    checkLiteral("async_rd_data", rd_data, 32'h0);
    checkLiteral("async_addr", {25'd0, dmi_req_addr}, 32'h0);
    checkLiteral("async_idle", {29'd0, idle}, 32'd5);
    tick(2);
    trst = 1'b1;
    tick(1);
    applyStimulus(1'b0, 1'b1, 7'h01, 32'h0, 1'b0, 1'b0);
    tick(1);
    sendRsp(32'h31415926, 1'b0);
    checkLiteral("after_trst_read", rd_data, 32'h31415926);
    tick(2);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/mcu_dmi_jtag_ctrl.md
MCU_DMI_JTAG_CTRL -- requirements
Module: mcu_dmi_jtag_ctrl

Interface
REQ-001 Parameter AWIDTH, default 7, SHALL set the DMI address width.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the WAIT_RSP cycle limit; legal range 1..65535.
REQ-003 Parameter IDLE_HINT, default 3'd1, SHALL be the value driven on idle.
REQ-004 tck  input  1  SHALL be the TAP clock; all state changes on posedge tck.
REQ-005 trst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 wr_en, rd_en  input  1 each  SHALL be one-cycle TAP operation pulses.
REQ-007 wr_addr  input  AWIDTH  SHALL be the DMI address from the TAP.
REQ-008 wr_data  input  32  SHALL be the DMI write data from the TAP.
REQ-009 dmi_reset, dmi_hard_reset  input  1 each  SHALL be TAP dmireset / dmihardreset pulses.
REQ-010 rd_data  output  32  SHALL be the last read response data, returned to the TAP.
REQ-011 rd_status  output  2  SHALL be the op status captured by the TAP.
REQ-012 dmi_stat  output  2  SHALL be the sticky DMI status.
REQ-013 idle  output  3  SHALL be the run-test-idle hint.
REQ-014 dmi_req_valid  output  1; dmi_req_ready  input  1  SHALL form the request handshake.
REQ-015 dmi_req_addr  output  AWIDTH; dmi_req_data  output  32; dmi_req_op  output  2  SHALL carry the request; op 1 = read, 2 = write.
REQ-016 dmi_rsp_valid  input  1; dmi_rsp_data  input  32; dmi_rsp_error  input  1  SHALL be the response; always accepted, no ready.

Function
REQ-017 The FSM SHALL have states IDLE, REQ and WAIT_RSP.
REQ-018 IDLE: wr_en xor rd_en with sticky==0 SHALL latch addr, data and op, then enter REQ; wr_en&rd_en SHALL be ignored.
REQ-019 REQ: dmi_req_valid=1 with addr, data and op held stable; dmi_req_valid&dmi_req_ready SHALL enter WAIT_RSP.
REQ-020 WAIT_RSP: dmi_rsp_valid SHALL return to IDLE.
REQ-021 On a read response, rd_data SHALL load dmi_rsp_data; writes SHALL leave rd_data unchanged.
REQ-022 dmi_rsp_error=1 SHALL set sticky=2'b10.
REQ-023 A 16-bit counter SHALL clear on entering WAIT_RSP and increment each WAIT_RSP cycle.
REQ-024 Counter reaching TIMEOUT without a response SHALL set sticky=2'b10, enter IDLE and set discard.
REQ-025 A response arriving in the timeout cycle SHALL win over the timeout.
REQ-026 Latency: TAP pulse at cycle N SHALL give dmi_req_valid=1 at N+1.
REQ-027 wr_en or rd_en while not IDLE SHALL be dropped and set sticky=2'b11 if sticky==0.
REQ-028 Any op while sticky!=0 SHALL be dropped with no request issued.
REQ-029 rd_status SHALL be sticky if nonzero, else 2'b11 when not IDLE, else 2'b00.
REQ-030 dmi_stat SHALL equal sticky; idle SHALL equal IDLE_HINT.
REQ-031 dmi_reset SHALL clear sticky next cycle and SHALL NOT abort an op in flight.
REQ-032 dmi_hard_reset SHALL force IDLE, clear sticky and counter, deassert dmi_req_valid next cycle and set discard if it aborted REQ or WAIT_RSP.
REQ-033 While discard=1, the first dmi_rsp_valid SHALL be dropped without updating rd_data or sticky, then discard SHALL clear; a new op also clears it.
REQ-034 Same-cycle priority SHALL be dmi_hard_reset > dmi_reset > new op.
REQ-035 dmi_rsp_valid outside WAIT_RSP with discard=0 SHALL be ignored.

Reset
REQ-036 trst low SHALL asynchronously force IDLE, counter=0, sticky=0, discard=0, rd_data=0, rd_status=0, dmi_stat=0, dmi_req_valid=0, dmi_req_addr=0, dmi_req_data=0, dmi_req_op=0.
REQ-037 idle SHALL equal IDLE_HINT during and after reset.
REQ-038 trst asserted mid-transaction SHALL drop the transaction with no discard tracking.

Structure
REQ-039 Package mcu_dmi_pkg SHALL hold the FSM state enum, op codes (NOP=0, RD=1, WR=2) and status codes (OK=0, FAILED=2, BUSY=3).
REQ-040 Single flat module, no sub-module; counter width SHALL be fixed at 16 bits.

Verification
REQ-041 rd_en addr 0x11, ready=1, response 0xDEADBEEF after 3 cycles -> rd_data=0xDEADBEEF, rd_status=0, one request issued.
REQ-042 wr_en during WAIT_RSP -> second op dropped, rd_status=3, dmi_stat=3; dmi_reset -> dmi_stat=0, the first op still completes.
REQ-043 TIMEOUT=4, no response -> IDLE after 4 WAIT_RSP cycles, dmi_stat=2; late response ignored, rd_data unchanged.
REQ-044 dmi_hard_reset in REQ with ready=0 -> dmi_req_valid=0 next cycle, state IDLE, sticky=0.
REQ-045 Write with dmi_rsp_error=1 -> dmi_stat=2; next rd_en -> no dmi_req_valid until dmi_reset.
REQ-046 trst asserted in WAIT_RSP -> all outputs 0 immediately, idle=IDLE_HINT.
